// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/redirect priority, compressed step and a circular return-address stack.
module pc_gen #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter int               RAS_DEPTH    = 4,
    parameter bit               C_EXT        = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            inst_is_c_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
    output logic            ras_empty_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d, mis_addr_q, seq_pc;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   tp_q, tp_inc, tp_dec;
    logic [CW-1:0]   cnt_q;
    logic            valid_q, mis_q, fire, ras_empty, mis_tgt, do_ret, push, pop, mis_ev;

    assign fire      = valid_q & pc_ready_i;
    assign seq_pc    = pc_q + ((C_EXT && inst_is_c_i) ? XLEN'(2) : XLEN'(4));
    assign ras_empty = cnt_q == '0;
    assign mis_tgt   = C_EXT ? redirect_pc_i[0] : |redirect_pc_i[1:0];
    assign mis_ev    = !trap_i & redirect_i & mis_tgt;
    assign do_ret    = fire & ret_i & !ras_empty;
    assign push      = fire & call_i;
    // Trap/redirect suppress the pop but never the call push.
    assign pop       = do_ret & !trap_i & !redirect_i;
    assign tp_inc    = (tp_q == PW'(RAS_DEPTH - 1)) ? '0 : tp_q + PW'(1);
    assign tp_dec    = (tp_q == '0) ? PW'(RAS_DEPTH - 1) : tp_q - PW'(1);

    always_comb begin
        pc_d = trap_i     ? (trap_vec_i & ~XLEN'(3)) :
               redirect_i ? (mis_tgt ? pc_q : redirect_pc_i) :
               do_ret     ? ras_q[tp_q] :
               fire       ? seq_pc : pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            tp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            mis_q   <= mis_ev;
            if (mis_ev)
                mis_addr_q <= redirect_pc_i;
            if (push && pop) begin
                ras_q[tp_q] <= seq_pc;
            end else if (push) begin
                ras_q[tp_inc] <= seq_pc;
                tp_q          <= tp_inc;
                cnt_q         <= (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
            end else if (pop) begin
                tp_q  <= tp_dec;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = valid_q;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
    assign ras_empty_o     = ras_empty;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen with hand-computed expectations.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst_n, pc_ready, inst_is_c, call, ret, redirect, trap;
    logic [31:0] redirect_pc, trap_vec, pc, mis_addr;
    logic        pc_valid, mis, ras_empty;
    int          assert_cnt = 0;
    int          fail_cnt = 0;

    pc_gen dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc), .pc_valid_o(pc_valid), .pc_ready_i(pc_ready),
        .inst_is_c_i(inst_is_c), .call_i(call), .ret_i(ret), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .trap_i(trap), .trap_vec_i(trap_vec),
        .misalign_o(mis), .misalign_addr_o(mis_addr), .ras_empty_o(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_ready = 0; inst_is_c = 0; call = 0; ret = 0; redirect = 0; trap = 0;
        redirect_pc = '0; trap_vec = '0;
    endtask

    task automatic jump(input logic [31:0] tgt);
        idle(); redirect = 1; redirect_pc = tgt; tick(); idle();
    endtask

    initial begin
        logic [31:0] seq_exp [6];
        logic        rdy_pat [6];
        logic [31:0] ret_exp [4];
        seq_exp = '{32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'h10};
        rdy_pat = '{1, 1, 1, 0, 0, 1};
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24};
        idle(); rst_n = 0;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'h0);
        check("rst_mis", {31'b0, mis}, 32'h0);
        check("rst_mis_addr", mis_addr, 32'h0);
        check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
        // Sequential run with a two-cycle stall
        rst_n = 1; pc_ready = 1;
        tick();
        check("rel_valid", {31'b0, pc_valid}, 32'h1);
        check("rel_pc", pc, 32'h0);
        for (int i = 0; i < 6; i++) begin
            pc_ready = rdy_pat[i];
            tick();
            check($sformatf("seq%0d", i), pc, seq_exp[i]);
        end
        // Compressed mix 1,0,1 from 0x100
        jump(32'h100);
        check("c_start", pc, 32'h100);
        pc_ready = 1;
        inst_is_c = 1; tick(); check("c0", pc, 32'h102);
        inst_is_c = 0; tick(); check("c1", pc, 32'h106);
        inst_is_c = 1; tick(); check("c2", pc, 32'h108);
        // Trap beats redirect, low bits of the vector cleared
        idle(); trap = 1; trap_vec = 32'h203; redirect = 1; redirect_pc = 32'h400; pc_ready = 1;
        tick();
        check("prio_pc", pc, 32'h200);
        check("prio_mis", {31'b0, mis}, 32'h0);
        // Misaligned redirect holds the PC and pulses the flag
        jump(32'h80);
        redirect = 1; redirect_pc = 32'h401; pc_ready = 1;
        tick();
        check("mis_pc", pc, 32'h80);
        check("mis_pulse", {31'b0, mis}, 32'h1);
        check("mis_addr", mis_addr, 32'h401);
        idle(); tick();
        check("mis_drop", {31'b0, mis}, 32'h0);
        check("mis_addr_hold", mis_addr, 32'h401);
        check("mis_pc_stall", pc, 32'h80);
        // Five calls into a 4-deep RAS, each combined with a redirect to the next call site
        jump(32'h10);
        for (int k = 1; k <= 5; k++) begin
            idle(); pc_ready = 1; call = 1; redirect = 1; redirect_pc = 32'h10 * (k + 1);
            tick();
        end
        idle();
        check("call_pc", pc, 32'h60);
        check("call_nonempty", {31'b0, ras_empty}, 32'h0);
        pc_ready = 1; ret = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ret%0d", i), pc, ret_exp[i]);
        end
        check("ret_empty", {31'b0, ras_empty}, 32'h1);
        tick();
        check("ret_empty_seq", pc, 32'h28);
        check("ret_empty_still", {31'b0, ras_empty}, 32'h1);
        // call+ret: empty -> sequential push; non-empty -> old top, top replaced
        call = 1; ret = 1;
        tick();
        check("cr_empty_pc", pc, 32'h2C);
        check("cr_empty_push", {31'b0, ras_empty}, 32'h0);
        tick();
        check("cr_pc", pc, 32'h2C);
        call = 0;
        tick();
        check("cr_replaced", pc, 32'h30);
        check("cr_count_kept", {31'b0, ras_empty}, 32'h1);
        // Wrap-around and reset during a stall with a pending ret
        jump(32'hFFFF_FFFC);
        pc_ready = 1;
        tick();
        check("wrap_pc", pc, 32'h0);
        jump(32'h40);
        idle(); pc_ready = 1; call = 1; tick();
        check("pre_rst_pc", pc, 32'h44);
        idle(); ret = 1; rst_n = 0;
        tick();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
        check("mid_rst_empty", {31'b0, ras_empty}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, giving the return-address-stack entry count; legal values are 2..16.
REQ-004 The block SHALL have parameter C_EXT, default 1, where 1 enables 2-byte compressed steps and 0 allows 4-byte steps only.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- pc_o  out  XLEN  current fetch PC
- pc_valid_o  out  1  pc_o is valid for fetch
- pc_ready_i  in  1  fetch accepts pc_o; fire = pc_valid_o & pc_ready_i
- inst_is_c_i  in  1  instruction at pc_o is compressed (step 2); ignored when C_EXT=0
- call_i  in  1  instruction at pc_o is a call; qualified by fire
- ret_i  in  1  instruction at pc_o is a return; qualified by fire
- redirect_i  in  1  branch/jump resolved-target redirect
- redirect_pc_i  in  XLEN  redirect target
- trap_i  in  1  trap entry request
- trap_vec_i  in  XLEN  trap vector base
- misalign_o  out  1  one-cycle pulse: redirect target was misaligned
- misalign_addr_o  out  XLEN  offending target; held until the next misalign pulse
- ras_empty_o  out  1  RAS holds no entries

Function
REQ-006 The block SHALL compute step as 2 when C_EXT=1 and inst_is_c_i=1, and as 4 otherwise.
REQ-007 The block SHALL perform all PC arithmetic modulo 2^XLEN, so that all-ones minus 1 plus 2 wraps to 0 with no flag.
REQ-008 The block SHALL select the next PC with priority trap_i > redirect_i > (fire & ret_i & !ras_empty_o) > fire > hold.
REQ-009 On trap_i, the block SHALL load pc_o with trap_vec_i having bits [1:0] forced to 0 on the next edge, regardless of pc_ready_i.
REQ-010 On redirect_i with an aligned target, the block SHALL load pc_o with redirect_pc_i on the next edge, regardless of pc_ready_i.
REQ-011 A redirect target SHALL be misaligned when bit 0 is set (C_EXT=1) or when either of bits [1:0] is set (C_EXT=0).
REQ-012 On a misaligned redirect, the block SHALL hold pc_o, assert misalign_o for exactly one cycle, and load misalign_addr_o with redirect_pc_i.
REQ-013 On fire with ret_i and a non-empty RAS, the block SHALL load pc_o with the RAS top and pop one entry.
REQ-014 On fire with no higher-priority event, the block SHALL load pc_o with pc_o + step.
REQ-015 Without fire, trap_i or redirect_i, the block SHALL hold pc_o unchanged (stall).
REQ-016 On fire with call_i, the block SHALL push pc_o + step onto the RAS, even when trap_i or redirect_i changes the next PC in the same cycle.
REQ-017 On fire with call_i and ret_i together, the block SHALL select the next PC from the old top, then replace the top with pc_o + step, leaving the entry count unchanged.
REQ-018 On a push while the RAS is full, the block SHALL overwrite the oldest entry circularly and keep the count saturated at RAS_DEPTH.
REQ-019 On a ret while the RAS is empty, the block SHALL perform no pop and take the sequential path of REQ-014.
REQ-020 The block SHALL leave RAS contents unaltered on trap_i and redirect_i, apart from the push of REQ-016.
REQ-021 The block SHALL deassert pc_valid_o only during reset; once asserted, pc_valid_o SHALL stay high.

Reset
REQ-022 While rst_n=0 at a rising edge, the block SHALL set pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, misalign_addr_o=0, RAS count=0 and ras_empty_o=1.
REQ-023 On the first edge with rst_n=1, the block SHALL assert pc_valid_o with pc_o=RESET_VECTOR.
REQ-024 A reset asserted mid-operation, including during stall, pending ret or full RAS, SHALL override all other inputs on that edge.

Verification
REQ-025 The bench SHALL cover a sequential run with stall: reset release with ready=1 for 3 cycles, ready=0 for 2 cycles, then ready=1 -> pc_o sequence 0,4,8,C,C,C,10.
REQ-026 The bench SHALL cover a compressed mix: with C_EXT=1 and inst_is_c_i pattern 1,0,1 from pc=0x100 -> pc_o 0x100,0x102,0x106,0x108.
REQ-027 The bench SHALL cover priority: trap_i and redirect_i asserted with trap_vec_i=0x203 and redirect_pc_i=0x400 -> next pc_o 0x200, misalign_o=0.
REQ-028 The bench SHALL cover misalignment: redirect_pc_i=0x401 at pc=0x80 -> pc_o holds 0x80, misalign_o pulses 1 cycle, misalign_addr_o=0x401.
REQ-029 The bench SHALL cover RAS overflow: with RAS_DEPTH=4, five calls at pcs 0x10,0x20,0x30,0x40,0x50 (step 4) followed by five rets -> ret targets 0x54,0x44,0x34,0x24, then the fifth ret is sequential and ras_empty_o=1.
REQ-030 The bench SHALL cover wrap-around and reset: at pc_o=0xFFFF_FFFC, fire -> pc_o=0; then asserting rst_n=0 mid-stall -> pc_o=RESET_VECTOR and pc_valid_o=0 on the next edge.
